board_link_rx: RTL

Receive end of the 11-bit inter-board link between the two game boards: bits [1:0] carry the game message, [9:2] the 8-bit shot address, bit [10] the address strobe. The link is driven by the other FPGA and is asynchronous to `clk`. The block synchronizes the link, filters glitches and decodes strobe-qualified addresses into a small FIFO. It also presents a debounced message to the game logic and game board on the 75 MHz domain.

---
 rtl/board_link_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/board_link_rx.sv
// board_link_rx: receive end of the inter-board link (sync, filter, address FIFO, message)
// Optional stability filtering is enabled by defining BOARD_LINK_RX_FILTER_EN.
module board_link_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [10:0]                   check_in,
    input  logic                          pop,
    output logic                          addr_valid,
    output logic [7:0]                    addr_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    msg_out,
    output logic                          msg_changed,
    output logic                          overflow,
    output logic                          runt_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT_STABLE, PUSH, WAIT_LOW} state_t;
    logic [10:0] sync1, sync2;
    logic s_strobe;
    logic [7:0] s_addr;
    logic [1:0] s_msg;
    logic prev_strobe, armed, rise;
    logic [1:0] primed;
    state_t state;
    logic [7:0] cand;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic full, do_pop, do_push;
    assign s_strobe   = sync2[10];
    assign s_addr     = sync2[9:2];
    assign s_msg      = sync2[1:0];
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign do_pop     = pop && count != '0;
    assign do_push    = state == PUSH && (!full || do_pop);
    // an edge only counts once the strobe has been seen low after reset
    assign rise       = s_strobe && !prev_strobe && armed;
    assign addr_valid = count != '0;
    assign addr_out   = addr_valid ? mem[rp] : 8'h00;
    assign fifo_count = count;
    // two-flop synchronizer on the whole link
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= check_in;
            sync2 <= sync1;
        end
    end
    // strobe history; arming waits until the synchronizer holds real samples
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_strobe <= 1'b0;
            primed      <= '0;
            armed       <= 1'b0;
        end else begin
            prev_strobe <= s_strobe;
            primed      <= {primed[0], 1'b1};
            armed       <= armed | (primed[1] & ~s_strobe);
        end
    end
`ifdef BOARD_LINK_RX_FILTER_EN
    logic [3:0] acnt, mcnt;
    logic [1:0] mcand;
    // address FSM with stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            acnt     <= '0;
            overflow <= 1'b0;
            runt_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    cand  <= s_addr;
                    acnt  <= 4'd1;
                    state <= WAIT_STABLE;
                end
                WAIT_STABLE: begin
                    if (!s_strobe) begin
                        runt_err <= 1'b1;
                        state    <= IDLE;
                    end else if (s_addr != cand) begin
                        cand <= s_addr;
                        acnt <= 4'd1;
                    end else if (acnt >= 4'(STABLE_CYCLES - 1)) begin
                        state <= PUSH;
                    end else begin
                        acnt <= acnt + 4'd1;
                    end
                end
                PUSH: begin
                    if (full && !do_pop) overflow <= 1'b1;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: if (!s_strobe) state <= IDLE;
            endcase
        end
    end
    // message candidate must hold before it replaces msg_out
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand       <= '0;
            mcnt        <= '0;
            msg_out     <= '0;
            msg_changed <= 1'b0;
        end else begin
            msg_changed <= 1'b0;
            if (s_msg != mcand) begin
                mcand <= s_msg;
                mcnt  <= '0;
            end else begin
                if (mcnt != 4'hF) mcnt <= mcnt + 4'd1;
                if ({1'b0, mcnt} + 5'd2 >= 5'(STABLE_CYCLES) && mcand != msg_out) begin
                    msg_out     <= mcand;
                    msg_changed <= 1'b1;
                end
            end
        end
    end
`else
    assign runt_err = 1'b0;
    // address FSM without filtering: capture on the strobe edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    cand  <= s_addr;
                    state <= PUSH;
                end
                WAIT_STABLE: state <= IDLE;
                PUSH: begin
                    if (full && !do_pop) overflow <= 1'b1;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: if (!s_strobe) state <= IDLE;
            endcase
        end
    end
    // message follows the synchronized value one stage later
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_out     <= '0;
            msg_changed <= 1'b0;
        end else begin
            msg_out     <= s_msg;
            msg_changed <= s_msg != msg_out;
        end
    end
`endif
    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // FIFO storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= cand;
    end
endmodule
